// File: rtl/prf_alloc_arb.sv
// prf_alloc_arb: round-robin arbiter sharing the free-list pop port, with a 1-entry prefetch buffer
// Ports: clk, rst (async, active-high); fl_valid/fl_ready/fl_free_idx = free-list pop side;
//        req_valid/req_ready = per-requester handshake (one-hot grant); alloc_idx = buffered index;
//        flush = suppress grants and restart round-robin at requester 0.
// Optional macro PRF_ALLOC_PERF_EN adds saturating perf_stall_cnt and perf_alloc_cnt outputs.
module prf_alloc_arb #(
  parameter int NUM_REQ = 2,
  parameter int PRF_IDX = 6
) (
  input  logic               clk,
  input  logic               rst,
  output logic               fl_valid,
  input  logic               fl_ready,
  input  logic [PRF_IDX-1:0] fl_free_idx,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [PRF_IDX-1:0] alloc_idx,
  input  logic               flush
`ifdef PRF_ALLOC_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_alloc_cnt
`endif
);
  localparam int PW = $clog2(NUM_REQ);
  logic               buf_valid;
  logic [PRF_IDX-1:0] buf_idx;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      win;
  logic               found;
  logic               fire;
  logic               pop;
  always_comb begin
    int s;
    s = 0;
    win = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(rr_ptr) + k;
      s = (s >= NUM_REQ) ? s - NUM_REQ : s;
      if (!found && req_valid[s]) begin
        found = 1'b1;
        win = PW'(s);
      end
    end
  end
  assign fire      = found & buf_valid & ~flush;
  assign req_ready = fire ? (NUM_REQ'(1) << win) : '0;
  assign alloc_idx = buf_valid ? buf_idx : '0;
  assign fl_valid  = ~rst & (~buf_valid | fire);
  assign pop       = fl_valid & fl_ready;
  // A fire that coincides with a pop replaces the buffer, sustaining one allocation per cycle.
  // Flush leaves the buffer alone: its index is already out of the free list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      rr_ptr    <= '0;
    end else begin
      buf_valid <= pop | (buf_valid & ~fire);
      if (pop) buf_idx <= fl_free_idx;
      rr_ptr <= flush ? '0 : fire ? ((win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1) : rr_ptr;
    end
  end
`ifdef PRF_ALLOC_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_alloc_cnt <= '0;
    end else begin
      if ((|req_valid) && !buf_valid && !flush && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (fire && perf_alloc_cnt != '1) perf_alloc_cnt <= perf_alloc_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_prf_alloc_arb.sv
// tb_prf_alloc_arb: directed self-checking bench for prf_alloc_arb
module tb_prf_alloc_arb;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fl_valid;
  logic       fl_ready = 1'b0;
  logic [5:0] fl_free_idx = '0;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [5:0] alloc_idx;
  logic       flush = 1'b0;
  int vectors = 0;
  int errors = 0;
`ifdef PRF_ALLOC_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_alloc_cnt;
`endif

  prf_alloc_arb #(.NUM_REQ(2), .PRF_IDX(6)) dut (
    .clk(clk),
    .rst(rst),
    .fl_valid(fl_valid),
    .fl_ready(fl_ready),
    .fl_free_idx(fl_free_idx),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .alloc_idx(alloc_idx),
    .flush(flush)
`ifdef PRF_ALLOC_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_alloc_cnt(perf_alloc_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change on negedge; outputs are sampled 1 time unit later, well before the next posedge.
  task automatic drive(input logic [1:0] rv, input logic fr, input logic [5:0] idx, input logic fl);
    @(negedge clk);
    req_valid = rv;
    fl_ready = fr;
    fl_free_idx = idx;
    flush = fl;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    fl_ready = 1'b1;
    fl_free_idx = 6'd32;
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (fl_valid !== 1'b0 || req_ready !== 2'b00 || alloc_idx !== 6'd0) begin
      errors++;
      $display("FAIL reset_hold: fl_valid=%b req_ready=%b alloc_idx=%0d want 0 00 0", fl_valid, req_ready, alloc_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (fl_valid !== 1'b1 || req_ready !== 2'b00 || alloc_idx !== 6'd0) begin
      errors++;
      $display("FAIL reset_release: fl_valid=%b req_ready=%b alloc_idx=%0d want 1 00 0", fl_valid, req_ready, alloc_idx);
    end
    drive(2'b00, 1'b1, 6'd32, 1'b0);
    vectors++;
    if (alloc_idx !== 6'd32 || req_ready !== 2'b00 || fl_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_fill: alloc_idx=%0d req_ready=%b fl_valid=%b want 32 00 0", alloc_idx, req_ready, fl_valid);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, 6'(33 + i), 1'b0);
      vectors++;
      if (req_ready !== exp_g[i] || alloc_idx !== 6'(32 + i) || fl_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_%0d: req_ready=%b alloc_idx=%0d fl_valid=%b want %b %0d 1", i, req_ready, alloc_idx, fl_valid, exp_g[i], 32 + i);
      end
    end
    drive(2'b01, 1'b1, 6'd40, 1'b0);
    vectors++;
    if (req_ready !== 2'b01 || alloc_idx !== 6'd36) begin
      errors++;
      $display("FAIL load_40: req_ready=%b alloc_idx=%0d want 01 36", req_ready, alloc_idx);
    end
  endtask

  task automatic test_flush;
    drive(2'b01, 1'b1, 6'd45, 1'b1);
    vectors++;
    if (req_ready !== 2'b00 || alloc_idx !== 6'd40 || fl_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: req_ready=%b alloc_idx=%0d fl_valid=%b want 00 40 0", req_ready, alloc_idx, fl_valid);
    end
    drive(2'b11, 1'b1, 6'd50, 1'b0);
    vectors++;
    if (req_ready !== 2'b01 || alloc_idx !== 6'd40) begin
      errors++;
      $display("FAIL post_flush: req_ready=%b alloc_idx=%0d want 01 40", req_ready, alloc_idx);
    end
  endtask

  task automatic test_empty_stall;
    drive(2'b10, 1'b0, 6'd0, 1'b0);
    vectors++;
    if (req_ready !== 2'b10 || alloc_idx !== 6'd50 || fl_valid !== 1'b1) begin
      errors++;
      $display("FAIL last_before_empty: req_ready=%b alloc_idx=%0d fl_valid=%b want 10 50 1", req_ready, alloc_idx, fl_valid);
    end
    for (int i = 0; i < 5; i++) begin
      drive(2'b10, 1'b0, 6'd0, 1'b0);
      vectors++;
      if (req_ready !== 2'b00 || alloc_idx !== 6'd0 || fl_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_%0d: req_ready=%b alloc_idx=%0d fl_valid=%b want 00 0 1", i, req_ready, alloc_idx, fl_valid);
      end
    end
    drive(2'b10, 1'b1, 6'd51, 1'b0);
    vectors++;
    if (req_ready !== 2'b00 || fl_valid !== 1'b1) begin
      errors++;
      $display("FAIL refill_cycle: req_ready=%b fl_valid=%b want 00 1", req_ready, fl_valid);
    end
    drive(2'b10, 1'b1, 6'd52, 1'b0);
    vectors++;
    if (req_ready !== 2'b10 || alloc_idx !== 6'd51) begin
      errors++;
      $display("FAIL after_refill: req_ready=%b alloc_idx=%0d want 10 51", req_ready, alloc_idx);
    end
  endtask

  task automatic test_async_reset;
    drive(2'b11, 1'b1, 6'd55, 1'b0);
    vectors++;
    if (alloc_idx !== 6'd52 || req_ready !== 2'b01) begin
      errors++;
      $display("FAIL pre_async: alloc_idx=%0d req_ready=%b want 52 01", alloc_idx, req_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (fl_valid !== 1'b0 || req_ready !== 2'b00 || alloc_idx !== 6'd0 || dut.buf_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: fl_valid=%b req_ready=%b alloc_idx=%0d buf_valid=%b want 0 00 0 0", fl_valid, req_ready, alloc_idx, dut.buf_valid);
    end
  endtask

  task automatic test_back_to_back_after_stall;
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b01;
    fl_ready = 1'b0;
    repeat (2) drive(2'b01, 1'b0, 6'd0, 1'b0);
    drive(2'b00, 1'b1, 6'd60, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 1'b1, 6'(61 + i), 1'b0);
      vectors++;
      if (req_ready !== 2'b01 || alloc_idx !== 6'(60 + i)) begin
        errors++;
        $display("FAIL b2b_%0d: req_ready=%b alloc_idx=%0d want 01 %0d", i, req_ready, alloc_idx, 60 + i);
      end
    end
    drive(2'b00, 1'b0, 6'd0, 1'b0);
`ifdef PRF_ALLOC_PERF_EN
    vectors++;
    if (perf_stall_cnt !== 32'd3 || perf_alloc_cnt !== 32'd4) begin
      errors++;
      $display("FAIL perf: stall=%0d alloc=%0d want 3 4", perf_stall_cnt, perf_alloc_cnt);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_flush;
    test_empty_stall;
    test_async_reset;
    test_back_to_back_after_stall;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
